sr_config_loader: RTL and testbench
===================================

// Module: sr_config_loader
// PURPOSE
//   Controller-side serializer for the PS-PWM configuration shift register.
//   Loads a parallel config word, then drives CLK_SR/Data_SR, LSB first, one bit per CLK_SR rising edge.
//   Word layout: dt[4:0], SELECTOR_SIGNAL_GENERATOR_1/2, OUTPUT_SELECTOR_EXTERNAL[3:0],
//   INPUT_SELECTOR, CLK_SELECTOR, PS_SELECTOR, PS3_SELECTOR, ENABLE_OUTPUT (MSB).
//   Replaces bench/firmware bit-banging; sits between the controller and the Top config port.
// PARAMETERS
//   CFG_WIDTH    18  config bits per frame (17 config + ENABLE_OUTPUT); >= 2
//   HALF_PERIOD  5   CLK cycles per CLK_SR low or high phase; >= 1
// PORTS
//   CLK        in   1          system clock; all logic on rising edge
//   RST_N      in   1          asynchronous, active-low reset
//   START      in   1          request a frame; sampled only in IDLE
//   ABORT      in   1          cancel the frame in progress
//   CFG_DATA   in   CFG_WIDTH  config word; captured on accepted START
//   BUSY       out  1          frame in progress
//   DONE       out  1          one-cycle pulse: frame completed normally
//   CLK_SR     out  1          shift clock to the config shift register
//   Data_SR    out  1          serial data to the config shift register
// BEHAVIOUR
//   - Reset (RST_N=0, async): all outputs 0, FSM=IDLE, counters 0.
//   - All outputs are registered; no combinational path from inputs to outputs.
//   - FSM states:
//     - IDLE: CLK_SR=0, Data_SR=0, BUSY=0.
//       - Exit: START=1 && ABORT=0 at edge k -> capture CFG_DATA into shreg, bit_idx=0, state SETUP.
//       - At k+1: BUSY=1, Data_SR=CFG_DATA[0].
//     - SETUP: CLK_SR=0, Data_SR=shreg[bit_idx], held HALF_PERIOD cycles.
//       - Then state HIGH.
//     - HIGH: CLK_SR=1, Data_SR unchanged, held HALF_PERIOD cycles.
//       - If bit_idx<CFG_WIDTH-1: bit_idx++, state SETUP. CLK_SR falls and Data_SR updates on the same edge;
//         the receiver samples on the rising edge, so setup = hold = HALF_PERIOD cycles.
//       - Else state TAIL.
//     - TAIL: CLK_SR=0, Data_SR=0, held HALF_PERIOD cycles.
//       - Then state IDLE with DONE=1 for exactly that cycle and BUSY=0.
//   - Frame length: BUSY high for exactly (2*CFG_WIDTH+1)*HALF_PERIOD cycles.
//     Exactly CFG_WIDTH CLK_SR rising edges per frame.
//   - Bit order: CFG_DATA[0] is first; CFG_DATA[CFG_WIDTH-1] (ENABLE_OUTPUT) is last.
//   - Phase counter: width $clog2(HALF_PERIOD+1). bit_idx: width $clog2(CFG_WIDTH).
//     bit_idx stops at CFG_WIDTH-1 (no wrap).
//   - START while BUSY: ignored, not queued.
//     CFG_DATA changes while BUSY: no effect; the captured copy is used.
//   - START in the DONE cycle is accepted (FSM is IDLE), so back-to-back frames are allowed.
//   - ABORT=1 in any non-IDLE state: next cycle FSM=IDLE, CLK_SR=0, Data_SR=0, BUSY=0, DONE=0.
//     ABORT=1 in IDLE blocks START in that cycle; ABORT wins.
//   - RST_N low mid-frame: outputs clear immediately, with no pending DONE.
//     The partial frame is not resumed after reset is released.
// TESTING
//   Bench uses HALF_PERIOD=2, CFG_WIDTH=18 and a rising-edge 18-bit receiver model
//   (first bit shifted in ends at index 0).
//   1. Reset: hold RST_N=0 with START=1 -> CLK_SR=Data_SR=BUSY=DONE=0.
//      Release RST_N with START=0 -> outputs stay 0.
//   2. Nominal frame: START pulse with CFG_DATA=18'h28103 ->
//      - 18 CLK_SR rising edges.
//      - Sampled bits 1,1,0,0,0,0,0,0,1,0,0,0,0,0,0,1,0,1.
//      - BUSY high for 74 cycles, then a single DONE pulse; receiver model = 18'h28103.
//   3. Mid-frame interference: START re-pulsed and CFG_DATA switched to 18'h3FFFF after the 4th rising edge ->
//      frame is unchanged (receiver = 18'h28103), exactly one DONE.
//   4. ABORT: ABORT=1 one cycle after the 3rd CLK_SR rise ->
//      - Next cycle: CLK_SR=0, Data_SR=0, BUSY=0.
//      - No DONE; total rising edges = 3.
//   5. Reset mid-frame: RST_N=0 during the 10th HIGH phase ->
//      - Outputs cleared asynchronously (before the next CLK edge).
//      - After release, START with 18'h00000 gives 18 edges, all data 0, and DONE.
//   6. Back-to-back: START held at 1, CFG_DATA=18'h3FFFF ->
//      - Second frame's BUSY rises the cycle after DONE.
//      - Each frame has 18 edges with data 1.

Source files
------------

// File: rtl/sr_config_loader.sv
// ---------------------------------------------------------------------------
// sr_config_loader
//   Controller-side serializer for the PS-PWM configuration shift register.
//   A START request captures the parallel config word, which is then shifted
//   out LSB first on Data_SR, one bit per rising edge of CLK_SR. A trailing
//   low phase closes the frame, followed by a one-cycle DONE pulse.
//
//   Every CLK_SR phase (low or high) lasts HALF_PERIOD system clocks.
//   Data_SR changes only on the CLK edge where CLK_SR falls. The receiver
//   therefore sees HALF_PERIOD cycles of setup and of hold around each
//   CLK_SR rise.
//
// Ports
//   CLK        in   system clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   START      in   frame request, honoured only while idle
//   ABORT      in   cancels a frame in progress; blocks START while idle
//   CFG_DATA   in   config word, captured when START is accepted
//   BUSY       out  frame in progress
//   DONE       out  one-cycle pulse when a frame completes normally
//   CLK_SR     out  shift clock to the config shift register
//   Data_SR    out  serial data to the config shift register
//   state_dbg  out  current FSM state (debug visibility)
//
// Handshake: START is a level request. It is accepted on the first rising
//   CLK edge where the FSM is idle, START=1 and ABORT=0. Requests made while
//   BUSY=1 are dropped, not queued. All outputs are registered.
// ---------------------------------------------------------------------------
module sr_config_loader #(
  parameter int CFG_WIDTH   = 18,
  parameter int HALF_PERIOD = 5
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [CFG_WIDTH-1:0] CFG_DATA,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 CLK_SR,
  output logic                 Data_SR,
  output logic [1:0]           state_dbg
);

  localparam int PH_W  = $clog2(HALF_PERIOD + 1);
  localparam int IDX_W = $clog2(CFG_WIDTH);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF_PERIOD - 1);
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CFG_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_TAIL  = 2'd3
  } state_t;

  state_t               state_q,   state_d;
  logic [PH_W-1:0]      phase_q,   phase_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [CFG_WIDTH-1:0] shreg_q,   shreg_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;
  logic                 clk_sr_q,  clk_sr_d;
  logic                 data_sr_q, data_sr_d;
  logic                 phase_end;

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    done_d    = 1'b0;
    phase_end = (phase_q == PH_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (START && !ABORT) begin
          state_d   = ST_SETUP;
          phase_d   = '0;
          bit_idx_d = '0;
          shreg_d   = CFG_DATA;
        end
      end

      ST_SETUP: begin
        if (phase_end) begin
          state_d = ST_HIGH;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end

      ST_HIGH: begin
        if (phase_end) begin
          phase_d = '0;
          // The bit index saturates at the last bit; the frame then goes to
          // the tail phase instead of wrapping.
          if (bit_idx_q != IDX_LAST) begin
            bit_idx_d = bit_idx_q + IDX_ONE;
            state_d   = ST_SETUP;
          end else begin
            state_d = ST_TAIL;
          end
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end

      ST_TAIL: begin
        if (phase_end) begin
          state_d = ST_IDLE;
          phase_d = '0;
          done_d  = 1'b1;
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase

    // ABORT overrides everything in a frame, including the final DONE.
    if (ABORT && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      phase_d   = '0;
      bit_idx_d = '0;
      done_d    = 1'b0;
    end

    // Outputs are decoded from the next state, so the registers hold the
    // values that belong to the state being entered.
    busy_d    = (state_d != ST_IDLE);
    clk_sr_d  = (state_d == ST_HIGH);
    data_sr_d = ((state_d == ST_SETUP) || (state_d == ST_HIGH)) ?
                shreg_d[bit_idx_d] : 1'b0;
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clk_sr_q  <= 1'b0;
      data_sr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      clk_sr_q  <= clk_sr_d;
      data_sr_q <= data_sr_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign CLK_SR    = clk_sr_q;
  assign Data_SR   = data_sr_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sr_config_loader.sv
// ---------------------------------------------------------------------------
// tb_sr_config_loader
//   Self-checking bench for sr_config_loader (CFG_WIDTH=18, HALF_PERIOD=2).
//   A negedge monitor acts as a rising-edge 18-bit receiver. It also counts
//   BUSY cycles and DONE pulses. Expected values come from the frame rules:
//   bits go out LSB first, there is one CLK_SR rise per bit, and BUSY lasts
//   (2*W+1)*HP cycles. For a frame aborted j cycles after BUSY rose, the
//   expected rise count is the number of bits i with HP*(2i+1) <= j.
// ---------------------------------------------------------------------------
module tb_sr_config_loader;

  localparam int W         = 18;
  localparam int HP        = 2;
  localparam int FRAME_CYC = (2 * W + 1) * HP;

  // ---------------- clock / reset ----------------
  logic         CLK      = 1'b0;
  logic         RST_N    = 1'b0;
  logic         START    = 1'b0;
  logic         ABORT    = 1'b0;
  logic [W-1:0] CFG_DATA = '0;
  logic         BUSY, DONE, CLK_SR, Data_SR;
  logic [1:0]   state_dbg;

  always #5 CLK = ~CLK;

  sr_config_loader #(.CFG_WIDTH(W), .HALF_PERIOD(HP)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .ABORT     (ABORT),
    .CFG_DATA  (CFG_DATA),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .CLK_SR    (CLK_SR),
    .Data_SR   (Data_SR),
    .state_dbg (state_dbg)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- monitor / receiver model ----------------
  int           rise_cnt    = 0;
  int           busy_cnt    = 0;
  int           done_cnt    = 0;
  int           done_ok_cnt = 0;
  int           b2b_cnt     = 0;
  logic         prev_clk_sr = 1'b0;
  logic         prev_busy   = 1'b0;
  logic         prev_done   = 1'b0;
  logic [W-1:0] rx_reg      = '0;
  logic         got_q[$];
  logic [W-1:0] exp_q[$];

  always @(negedge CLK) begin
    if (BUSY === 1'b1) busy_cnt++;
    if (DONE === 1'b1) begin
      done_cnt++;
      if (prev_busy && !BUSY) done_ok_cnt++;
    end
    if ((BUSY === 1'b1) && !prev_busy && prev_done) b2b_cnt++;
    if ((CLK_SR === 1'b1) && !prev_clk_sr) begin
      rise_cnt++;
      got_q.push_back(Data_SR);
      rx_reg = {Data_SR, rx_reg[W-1:1]};
    end
    prev_clk_sr = (CLK_SR === 1'b1);
    prev_busy   = (BUSY === 1'b1);
    prev_done   = (DONE === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    rise_cnt    = 0;
    busy_cnt    = 0;
    done_cnt    = 0;
    done_ok_cnt = 0;
    b2b_cnt     = 0;
    rx_reg      = '0;
    got_q.delete();
  endtask

  // Returns one cycle into the frame (first BUSY cycle).
  task automatic start_frame(input logic [W-1:0] data);
    @(posedge CLK); #1;
    CFG_DATA = data;
    START    = 1'b1;
    @(posedge CLK); #1;
    START    = 1'b0;
  endtask

  task automatic wait_rise(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK); #1;
      if (rise_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK); #1;
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N = 1'b0;
    START = 1'b1;
    repeat (3) @(negedge CLK);
    if ({CLK_SR, Data_SR, BUSY, DONE} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_hold: outputs=%b want 0000", {CLK_SR, Data_SR, BUSY, DONE});
    end
    total++;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    if ({CLK_SR, Data_SR, BUSY, DONE} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_release: outputs=%b want 0000", {CLK_SR, Data_SR, BUSY, DONE});
    end
    total++;
  endtask

  task automatic test_nominal();
    logic [W-1:0] d;
    bit           ok;
    d = 18'h28103;
    clear_mon();
    start_frame(d);
    @(negedge CLK);
    if ({BUSY, CLK_SR, Data_SR} !== {1'b1, 1'b0, d[0]}) begin
      bad++;
      $display("FAIL nominal_first_cycle: busy/clk/data=%b want %b",
               {BUSY, CLK_SR, Data_SR}, {1'b1, 1'b0, d[0]});
    end
    total++;
    wait_done(1, ok);
    if (!ok) begin
      bad++;
      $display("FAIL nominal_timeout: no DONE seen");
    end
    total++;
    repeat (4) @(negedge CLK);
    if (rise_cnt != W) begin
      bad++;
      $display("FAIL nominal_rises: got %0d want %0d", rise_cnt, W);
    end
    total++;
    for (int i = 0; i < W; i++) begin
      if (i < got_q.size()) begin
        if (got_q[i] !== d[i]) begin
          bad++;
          $display("FAIL nominal_bit%0d: got %b want %b", i, got_q[i], d[i]);
        end
        total++;
      end
    end
    if (busy_cnt != FRAME_CYC) begin
      bad++;
      $display("FAIL nominal_busy_len: got %0d want %0d", busy_cnt, FRAME_CYC);
    end
    total++;
    if ((done_cnt != 1) || (done_ok_cnt != 1)) begin
      bad++;
      $display("FAIL nominal_done: pulses=%0d after_busy=%0d want 1/1", done_cnt, done_ok_cnt);
    end
    total++;
    if (rx_reg !== d) begin
      bad++;
      $display("FAIL nominal_rx: got %h want %h", rx_reg, d);
    end
    total++;
  endtask

  task automatic test_interference();
    logic [W-1:0] d;
    bit           ok;
    d = 18'h28103;
    clear_mon();
    start_frame(d);
    wait_rise(4, ok);
    @(posedge CLK); #1;
    START    = 1'b1;
    CFG_DATA = 18'h3FFFF;
    repeat (3) @(posedge CLK);
    #1;
    START = 1'b0;
    wait_done(1, ok);
    repeat (FRAME_CYC) @(negedge CLK);
    if ((rx_reg !== d) || (rise_cnt != W)) begin
      bad++;
      $display("FAIL interference_rx: got %h/%0d want %h/%0d", rx_reg, rise_cnt, d, W);
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL interference_done: got %0d want 1", done_cnt);
    end
    total++;
  endtask

  task automatic test_abort();
    logic [W-1:0] d;
    bit           ok;
    d = W'($urandom);
    clear_mon();
    start_frame(d);
    wait_rise(3, ok);
    @(posedge CLK); #1;
    ABORT = 1'b1;
    @(posedge CLK); #1;
    ABORT = 1'b0;
    @(negedge CLK);
    if ({CLK_SR, Data_SR, BUSY} !== 3'b000) begin
      bad++;
      $display("FAIL abort_clear: clk/data/busy=%b want 000", {CLK_SR, Data_SR, BUSY});
    end
    total++;
    repeat (FRAME_CYC + 4) @(negedge CLK);
    if ((done_cnt != 0) || (rise_cnt != 3)) begin
      bad++;
      $display("FAIL abort_counts: done=%0d rises=%0d want 0/3", done_cnt, rise_cnt);
    end
    total++;
  endtask

  task automatic test_random_abort();
    logic [W-1:0] d;
    int           j;
    int           exp_rises;
    int           offs[4];
    offs[0] = 0;
    offs[1] = $urandom_range(1, FRAME_CYC - 2);
    offs[2] = $urandom_range(1, FRAME_CYC - 2);
    offs[3] = FRAME_CYC - 1;
    for (int n = 0; n < 4; n++) begin
      j = offs[n];
      d = W'($urandom);
      exp_rises = 0;
      for (int i = 0; i < W; i++) if (HP * (2 * i + 1) <= j) exp_rises++;
      clear_mon();
      start_frame(d);
      repeat (j) @(posedge CLK);
      #1;
      ABORT = 1'b1;
      @(posedge CLK); #1;
      ABORT = 1'b0;
      repeat (FRAME_CYC + 4) @(negedge CLK);
      if ((rise_cnt != exp_rises) || (done_cnt != 0) || (BUSY !== 1'b0)) begin
        bad++;
        $display("FAIL rand_abort_j%0d: rises=%0d done=%0d busy=%b want %0d/0/0",
                 j, rise_cnt, done_cnt, BUSY, exp_rises);
      end
      total++;
      for (int i = 0; i < got_q.size(); i++) begin
        if (got_q[i] !== d[i]) begin
          bad++;
          $display("FAIL rand_abort_bit%0d: got %b want %b", i, got_q[i], d[i]);
        end
        total++;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] d;
    bit           ok;
    d = W'($urandom);
    clear_mon();
    start_frame(d);
    wait_rise(10, ok);
    #1;
    RST_N = 1'b0;
    #1;
    if ({CLK_SR, Data_SR, BUSY, DONE} !== 4'b0000) begin
      bad++;
      $display("FAIL midreset_async: outputs=%b want 0000", {CLK_SR, Data_SR, BUSY, DONE});
    end
    total++;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    repeat (FRAME_CYC + 4) @(negedge CLK);
    if ((rise_cnt != 10) || (done_cnt != 0) || (BUSY !== 1'b0)) begin
      bad++;
      $display("FAIL midreset_no_resume: rises=%0d done=%0d busy=%b want 10/0/0",
               rise_cnt, done_cnt, BUSY);
    end
    total++;
    clear_mon();
    start_frame('0);
    wait_done(1, ok);
    repeat (2) @(negedge CLK);
    if ((rise_cnt != W) || (rx_reg !== '0) || (done_cnt != 1)) begin
      bad++;
      $display("FAIL midreset_zero_frame: rises=%0d rx=%h done=%0d want %0d/0/1",
               rise_cnt, rx_reg, done_cnt, W);
    end
    total++;
  endtask

  task automatic test_random_frames();
    logic [W-1:0] d;
    bit           ok;
    for (int n = 0; n < 4; n++) begin
      d = W'($urandom);
      exp_q.push_back(d);
      clear_mon();
      start_frame(d);
      // Noise on START/CFG_DATA must not disturb the captured word.
      for (int c = 0; c < 60; c++) begin
        @(posedge CLK); #1;
        START    = 1'($urandom_range(0, 1));
        CFG_DATA = W'($urandom);
      end
      START = 1'b0;
      wait_done(1, ok);
      d = exp_q.pop_front();
      if ((rx_reg !== d) || (rise_cnt != W) || (busy_cnt != FRAME_CYC) || !ok) begin
        bad++;
        $display("FAIL rand_frame%0d: rx=%h rises=%0d busy=%0d want %h/%0d/%0d",
                 n, rx_reg, rise_cnt, busy_cnt, d, W, FRAME_CYC);
      end
      total++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int ones;
    clear_mon();
    @(posedge CLK); #1;
    CFG_DATA = 18'h3FFFF;
    START    = 1'b1;
    wait_done(2, ok);
    START = 1'b0;
    if (!ok) begin
      bad++;
      $display("FAIL b2b_timeout: done pulses=%0d want 2", done_cnt);
    end
    total++;
    repeat (FRAME_CYC) @(negedge CLK);
    if (b2b_cnt != 1) begin
      bad++;
      $display("FAIL b2b_restart: busy-after-done=%0d want 1", b2b_cnt);
    end
    total++;
    ones = 0;
    foreach (got_q[i]) if (got_q[i] === 1'b1) ones++;
    if ((rise_cnt != 2 * W) || (ones != 2 * W)) begin
      bad++;
      $display("FAIL b2b_bits: rises=%0d ones=%0d want %0d/%0d", rise_cnt, ones, 2 * W, 2 * W);
    end
    total++;
    if ((done_cnt != 2) || (busy_cnt != 2 * FRAME_CYC)) begin
      bad++;
      $display("FAIL b2b_frames: done=%0d busy=%0d want 2/%0d", done_cnt, busy_cnt, 2 * FRAME_CYC);
    end
    total++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_nominal();
    test_interference();
    test_abort();
    test_random_abort();
    test_reset_mid_frame();
    test_random_frames();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
